line_buffer_3row: RTL and testbench

- Converts a raster-order pixel stream into three vertically aligned row streams (rows y-2, y-1, y) for the 3x3 window / Laplacian stage.
- Holds two full image lines in internal line memories.
- Sits between the camera/pixel source and the 3x3 matrix block, driving its valid_in/din1/din2/din3.
- Also supplies the column/row position of each output triple, plus end-of-line and end-of-frame pulses.

---
 rtl/line_buffer_3row.sv | 98 +++++++++
 tb/tb_line_buffer_3row.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/line_buffer_3row.sv
// Three-row line buffer: turns a raster pixel stream into vertically aligned
// triples (rows y-2, y-1, y) with their column/row position and line/frame pulses.
module line_buffer_3row #(
  parameter int WIDTH      = 24,
  parameter int PIC_WIDTH  = 320,
  parameter int PIC_HEIGHT = 240
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic             sof,
  input  logic [WIDTH-1:0] din,
  output logic             valid_out,
  output logic [WIDTH-1:0] dout1,
  output logic [WIDTH-1:0] dout2,
  output logic [WIDTH-1:0] dout3,
  output logic [8:0]       col_out,
  output logic [8:0]       row_out,
  output logic             eol,
  output logic             eof
);

  localparam int         AW       = (PIC_WIDTH > 1) ? $clog2(PIC_WIDTH) : 1;
  localparam int         DEPTH    = 1 << AW;
  localparam logic [8:0] COL_LAST = 9'(PIC_WIDTH - 1);
  localparam logic [8:0] ROW_LAST = 9'(PIC_HEIGHT - 1);
  localparam logic [8:0] ROW_FIRST_OUT = 9'd2;

  function automatic logic [8:0] wrap_inc(input logic [8:0] v, input logic [8:0] last);
    return (v == last) ? 9'd0 : v + 9'd1;
  endfunction

  logic [8:0]       col;
  logic [8:0]       row;
  logic [8:0]       col_p0;
  logic [8:0]       row_p0;
  logic [AW-1:0]    addr_p0;
  logic [WIDTH-1:0] rd0_p0;
  logic [WIDTH-1:0] rd1_p0;
  logic             line_end_p0;

  logic [WIDTH-1:0] mem0 [DEPTH];
  logic [WIDTH-1:0] mem1 [DEPTH];

  // Stage p0: effective position (sof forces 0,0) and memory read.
  always_comb begin
    col_p0      = sof ? 9'd0 : col;
    row_p0      = sof ? 9'd0 : row;
    addr_p0     = col_p0[AW-1:0];
    rd0_p0      = mem0[addr_p0];
    rd1_p0      = mem1[addr_p0];
    line_end_p0 = (col_p0 == COL_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= 9'd0;
      row <= 9'd0;
    end else if (valid_in) begin
      col <= wrap_inc(col_p0, COL_LAST);
      row <= line_end_p0 ? wrap_inc(row_p0, ROW_LAST) : row_p0;
    end
  end

  // Line memories shift one row per write: mem0 holds y-1, mem1 holds y-2.
  always_ff @(posedge clk) begin
    if (valid_in) begin
      mem0[addr_p0] <= din;
      mem1[addr_p0] <= rd0_p0;
    end
  end

  // Stage p1: registered outputs, one cycle after valid_in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out <= 1'b0;
      eol       <= 1'b0;
      eof       <= 1'b0;
      dout1     <= '0;
      dout2     <= '0;
      dout3     <= '0;
      col_out   <= 9'd0;
      row_out   <= 9'd0;
    end else begin
      valid_out <= valid_in && (row_p0 >= ROW_FIRST_OUT);
      eol       <= valid_in && (row_p0 >= ROW_FIRST_OUT) && line_end_p0;
      eof       <= valid_in && (row_p0 == ROW_LAST) && line_end_p0;
      if (valid_in) begin
        dout3   <= din;
        dout2   <= rd0_p0;
        dout1   <= rd1_p0;
        col_out <= col_p0;
        row_out <= row_p0;
      end
    end
  end

endmodule

// File: tb/tb_line_buffer_3row.sv
// Scoreboard bench for line_buffer_3row on a 4x4 picture: a frame-image
// reference model predicts each output triple; a monitor pops and compares.
module tb_line_buffer_3row;

  localparam int W  = 24;
  localparam int PW = 4;
  localparam int PH = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         valid_in = 1'b0;
  logic         sof = 1'b0;
  logic [W-1:0] din = '0;
  logic         valid_out;
  logic [W-1:0] dout1, dout2, dout3;
  logic [8:0]   col_out, row_out;
  logic         eol, eof;

  line_buffer_3row #(.WIDTH(W), .PIC_WIDTH(PW), .PIC_HEIGHT(PH)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .sof(sof), .din(din),
    .valid_out(valid_out), .dout1(dout1), .dout2(dout2), .dout3(dout3),
    .col_out(col_out), .row_out(row_out), .eol(eol), .eof(eof)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d1, d2, d3;
    int           col, row;
    bit           eol, eof;
  } exp_t;

  exp_t         q[$];
  exp_t         mon_e;
  int           checks = 0;
  int           errors = 0;
  int           mx = 0, my = 0;
  logic [W-1:0] img [PH][PW];
  int           exp_eol = 0, exp_eof = 0, got_eol = 0, got_eof = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: the current frame as a 2-D image; a triple at (x,y) is the
  // column x of rows y-2, y-1, y once y >= 2.
  task automatic model(input logic [W-1:0] p, input bit s);
    exp_t e;
    if (s) begin mx = 0; my = 0; end
    img[my][mx] = p;
    if (my >= 2) begin
      e.d1 = img[my-2][mx]; e.d2 = img[my-1][mx]; e.d3 = p;
      e.col = mx; e.row = my;
      e.eol = (mx == PW-1);
      e.eof = (my == PH-1) && (mx == PW-1);
      q.push_back(e);
      if (e.eol) exp_eol++;
      if (e.eof) exp_eof++;
    end
    mx++;
    if (mx == PW) begin
      mx = 0;
      my = (my == PH-1) ? 0 : my + 1;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_out) begin
        if (eol) got_eol++;
        if (eof) got_eof++;
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_valid_out actual=1 required=0 at %0t", $time);
        end else begin
          mon_e = q.pop_front();
          chk("dout1", 64'(dout1), 64'(mon_e.d1));
          chk("dout2", 64'(dout2), 64'(mon_e.d2));
          chk("dout3", 64'(dout3), 64'(mon_e.d3));
          chk("col_out", 64'(col_out), 64'(mon_e.col));
          chk("row_out", 64'(row_out), 64'(mon_e.row));
          chk("eol", 64'(eol), 64'(mon_e.eol));
          chk("eof", 64'(eof), 64'(mon_e.eof));
        end
      end else begin
        chk("eol_without_valid", 64'(eol), 64'd0);
        chk("eof_without_valid", 64'(eof), 64'd0);
      end
    end
  end

  // One clock cycle of stimulus; entered and left at posedge+2.
  task automatic send(input logic [W-1:0] p, input bit s, input bit v);
    logic [W-1:0] h1, h2, h3;
    logic [8:0]   hc, hr;
    valid_in = v; sof = s; din = p;
    h1 = dout1; h2 = dout2; h3 = dout3; hc = col_out; hr = row_out;
    if (v) model(p, s);
    @(posedge clk); #2;
    if (!v) begin
      chk("gap_hold_dout1", 64'(dout1), 64'(h1));
      chk("gap_hold_dout2", 64'(dout2), 64'(h2));
      chk("gap_hold_dout3", 64'(dout3), 64'(h3));
      chk("gap_hold_pos", 64'({col_out, row_out}), 64'({hc, hr}));
      chk("gap_valid_out", 64'(valid_out), 64'd0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send('0, 1'b0, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid_out"}, 64'(valid_out), 64'd0);
    chk({tag, "_douts"}, 64'(dout1 | dout2 | dout3), 64'd0);
    chk({tag, "_pos"}, 64'({col_out, row_out}), 64'd0);
    chk({tag, "_flags"}, 64'({eol, eof}), 64'd0);
  endtask

  task automatic do_reset(input string tag);
    valid_in = 1'b0; sof = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_zero(tag);
    chk({tag, "_pending"}, 64'(q.size()), 64'd0);
    q.delete();
    mx = 0; my = 0;
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  // mode 0: pattern continuous, 1: pattern gapped, 2: all ones continuous
  task automatic frame(input int mode, input bit with_sof);
    logic [W-1:0] p;
    for (int r = 0; r < PH; r++)
      for (int c = 0; c < PW; c++) begin
        p = (mode == 2) ? {W{1'b1}} : W'(r*16 + c);
        send(p, with_sof && r == 0 && c == 0, 1'b1);
        if (mode == 1) send('0, 1'b0, 1'b0);
      end
  endtask

  initial begin
    #1;
    check_zero("reset_state");
    @(posedge clk); #2;
    rst_n = 1'b1;

    frame(0, 1'b1);
    idle(2);
    frame(1, 1'b0);
    idle(2);

    // sof at row 1 col 2 of a frame
    for (int i = 0; i < PW + 2; i++) send(W'((i / PW) * 16 + (i % PW)), 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) send(W'(8'hA0 + i), i == 0, 1'b1);
    idle(2);

    // back-to-back frames, sof only on the first
    frame(0, 1'b1);
    frame(0, 1'b0);
    idle(2);

    // reset after 10 pixels, then a frame from (0,0)
    for (int i = 0; i < 10; i++) send(W'(8'h50 + i), 1'b0, 1'b1);
    do_reset("reset_mid_frame");
    frame(0, 1'b0);

    // reset inside a gap
    for (int i = 0; i < 10; i++) begin
      send(W'(8'h60 + i), 1'b0, 1'b1);
      send('0, 1'b0, 1'b0);
    end
    do_reset("reset_in_gap");
    frame(1, 1'b0);

    frame(2, 1'b1);
    idle(2);

    for (int i = 0; i < 400; i++)
      send(W'($urandom), ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0));
    idle(3);

    chk("queue_drained", 64'(q.size()), 64'd0);
    chk("eol_count", 64'(got_eol), 64'(exp_eol));
    chk("eof_count", 64'(got_eof), 64'(exp_eof));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
